// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register for a small MIPS subset.
// Holds the 32-entry register file with a write-through bypass from write-back.
module id_ex_stage #(
   parameter int NREG = 32,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ValidD,
   input  logic [31:0]     InstrD,
   input  logic            StallE,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      WriteRegW,
   input  logic [XLEN-1:0] ResultW,
   output logic            ValidE,
   output logic [2:0]      ALUControlE,
   output logic            ALUSrcE,
   output logic [XLEN-1:0] SignImmE,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   output logic            RegWriteE,
   output logic            MemToRegE,
   output logic            MemWriteE,
   output logic [4:0]      WriteRegE,
   output logic            IllegalE
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] F_ADD    = 6'b100000;
   localparam logic [5:0] F_AND    = 6'b100100;
   localparam logic [5:0] F_OR     = 6'b100101;
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_AND  = 3'b111;
   localparam logic [2:0] ALU_OR   = 3'b110;

   typedef struct packed {
      logic            valid;
      logic            illegal;
      logic [2:0]      alu;
      logic            src;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic            regwrite;
      logic            memtoreg;
      logic            memwrite;
      logic [4:0]      wreg;
   } ex_bundle_t;

   logic [XLEN-1:0] regs [NREG];
   logic [5:0]      op;
   logic [5:0]      funct;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [15:0]     imm16;
   logic [XLEN-1:0] sign_imm;
   logic [XLEN-1:0] zero_imm;
   logic [XLEN-1:0] rd1_d;
   logic [XLEN-1:0] rd2_d;
   logic            wb_active;
   logic            legal;
   ex_bundle_t      d_bundle;
   ex_bundle_t      e_bundle;

   assign op       = InstrD[31:26];
   assign rs       = InstrD[25:21];
   assign rt       = InstrD[20:16];
   assign rd       = InstrD[15:11];
   assign funct    = InstrD[5:0];
   assign imm16    = InstrD[15:0];
   assign sign_imm = {{(XLEN-16){imm16[15]}}, imm16};
   assign zero_imm = {{(XLEN-16){1'b0}}, imm16};

   // r0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (RegWriteW && (WriteRegW != 5'd0)) begin
         regs[WriteRegW] <= ResultW;
      end
   end

   assign wb_active = RegWriteW && (WriteRegW != 5'd0);

   // Write-through: a same-cycle write-back is visible to the decoding instruction.
   always_comb begin
      rd1_d = regs[rs];
      rd2_d = regs[rt];
      if (rs == 5'd0)                         rd1_d = '0;
      else if (wb_active && WriteRegW == rs)  rd1_d = ResultW;
      if (rt == 5'd0)                         rd2_d = '0;
      else if (wb_active && WriteRegW == rt)  rd2_d = ResultW;
   end

   // ValidD qualifies InstrD for one cycle; ValidE marks a real instruction in E,
   // with IllegalE flagging an unsupported encoding that travels as a bubble.
   always_comb begin
      d_bundle = '0;
      legal    = 1'b1;
      if (ValidD) begin
         d_bundle.valid = 1'b1;
         d_bundle.imm   = sign_imm;
         d_bundle.rd1   = rd1_d;
         d_bundle.rd2   = rd2_d;
         d_bundle.wreg  = rt;
         case (op)
            OP_RTYPE: begin
               d_bundle.wreg     = rd;
               d_bundle.regwrite = 1'b1;
               case (funct)
                  F_ADD:   d_bundle.alu = ALU_ADD;
                  F_AND:   d_bundle.alu = ALU_AND;
                  F_OR:    d_bundle.alu = ALU_OR;
                  default: legal = 1'b0;
               endcase
            end
            OP_ADDI: begin
               d_bundle.alu      = ALU_ADD;
               d_bundle.src      = 1'b1;
               d_bundle.regwrite = 1'b1;
            end
            OP_ANDI: begin
               d_bundle.alu      = ALU_AND;
               d_bundle.src      = 1'b1;
               d_bundle.regwrite = 1'b1;
               d_bundle.imm      = zero_imm;
            end
            OP_ORI: begin
               d_bundle.alu      = ALU_OR;
               d_bundle.src      = 1'b1;
               d_bundle.regwrite = 1'b1;
               d_bundle.imm      = zero_imm;
            end
            OP_LW: begin
               d_bundle.alu      = ALU_ADD;
               d_bundle.src      = 1'b1;
               d_bundle.regwrite = 1'b1;
               d_bundle.memtoreg = 1'b1;
            end
            OP_SW: begin
               d_bundle.alu      = ALU_ADD;
               d_bundle.src      = 1'b1;
               d_bundle.memwrite = 1'b1;
            end
            default: legal = 1'b0;
         endcase
         if (!legal) begin
            d_bundle         = '0;
            d_bundle.valid   = 1'b1;
            d_bundle.illegal = 1'b1;
         end
      end
   end

   // Flush beats stall; a stalled register ignores write-back updates to its operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_bundle <= '0;
      end else if (FlushE) begin
         e_bundle <= '0;
      end else if (!StallE) begin
         e_bundle <= d_bundle;
      end
   end

   assign ValidE      = e_bundle.valid;
   assign IllegalE    = e_bundle.illegal;
   assign ALUControlE = e_bundle.alu;
   assign ALUSrcE     = e_bundle.src;
   assign SignImmE    = e_bundle.imm;
   assign RD1         = e_bundle.rd1;
   assign RD2         = e_bundle.rd2;
   assign RegWriteE   = e_bundle.regwrite;
   assign MemToRegE   = e_bundle.memtoreg;
   assign MemWriteE   = e_bundle.memwrite;
   assign WriteRegE   = e_bundle.wreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instructions, expected E bundles queued at issue
// and compared by an independent monitor one clock later.
module tb_id_ex_stage;

   typedef logic [109:0] bundle_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ValidD;
   logic [31:0] InstrD;
   logic        StallE;
   logic        FlushE;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        ValidE;
   logic [2:0]  ALUControlE;
   logic        ALUSrcE;
   logic [31:0] SignImmE;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic        RegWriteE;
   logic        MemToRegE;
   logic        MemWriteE;
   logic [4:0]  WriteRegE;
   logic        IllegalE;

   bundle_t     got;
   bundle_t     exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .InstrD(InstrD),
      .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW),
      .WriteRegW(WriteRegW), .ResultW(ResultW), .ValidE(ValidE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .SignImmE(SignImmE),
      .RD1(RD1), .RD2(RD2), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
      .MemWriteE(MemWriteE), .WriteRegE(WriteRegE), .IllegalE(IllegalE)
   );

   // clock / reset
   always #5 clk = ~clk;

   assign got = {ValidE, IllegalE, ALUControlE, ALUSrcE, SignImmE, RD1, RD2,
                 RegWriteE, MemToRegE, MemWriteE, WriteRegE};

   function automatic bundle_t mk(input logic v, input logic ill, input logic [2:0] alu,
                                  input logic src, input logic [31:0] imm,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic rw, input logic m2r, input logic mw,
                                  input logic [4:0] wr);
      return {v, ill, alu, src, imm, r1, r2, rw, m2r, mw, wr};
   endfunction

   task automatic compare(input string name, input bundle_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // driver tasks
   task automatic issue(input string name, input logic v, input logic [31:0] ins,
                        input logic st, input logic fl, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd, input bundle_t exp);
      @(negedge clk);
      #1;
      ValidD = v; InstrD = ins; StallE = st; FlushE = fl;
      RegWriteW = we; WriteRegW = wr; ResultW = wd;
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic idle();
      @(negedge clk);
      #1;
      ValidD = 1'b0; InstrD = '0; StallE = 1'b0; FlushE = 1'b0;
      RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
   endtask

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            bundle_t e;
            string   n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compare(n, e);
         end
      end
   end

   bundle_t zero_b;
   bundle_t sw_b;

   initial begin
      zero_b = '0;
      sw_b   = mk(1, 0, 3'b000, 1, 32'h8, 32'h100, 32'h3, 0, 0, 1, 5'd6);
      rst_n = 1'b0; ValidD = 1'b0; InstrD = '0; StallE = 1'b0; FlushE = 1'b0;
      RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
      repeat (3) @(posedge clk);
      #1 compare("reset_init", zero_b);
      @(negedge clk);
      rst_n = 1'b1;

      issue("wb_r5", 0, 32'h0, 0, 0, 1, 5'd5, 32'h10, zero_b);
      issue("wb_r6", 0, 32'h0, 0, 0, 1, 5'd6, 32'h3, zero_b);
      issue("add_7_5_6", 1, 32'h00A63820, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b000, 0, 32'h3820, 32'h10, 32'h3, 1, 0, 0, 5'd7));
      issue("wb_r1", 0, 32'h0, 0, 0, 1, 5'd1, 32'h100, zero_b);
      issue("andi_zext", 1, 32'h3022FFFF, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b111, 1, 32'h0000FFFF, 32'h100, 32'h0, 1, 0, 0, 5'd2));
      issue("lw_sext", 1, 32'h8C22FFFC, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b000, 1, 32'hFFFFFFFC, 32'h100, 32'h0, 1, 1, 0, 5'd2));
      issue("or_bypass", 1, 32'h00A01825, 0, 0, 1, 5'd5, 32'hDEADBEEF,
            mk(1, 0, 3'b110, 0, 32'h1825, 32'hDEADBEEF, 32'h0, 1, 0, 0, 5'd3));
      issue("wb_r0_bypass", 1, 32'h00052020, 0, 0, 1, 5'd0, 32'h12345678,
            mk(1, 0, 3'b000, 0, 32'h2020, 32'h0, 32'hDEADBEEF, 1, 0, 0, 5'd4));
      issue("r0_reads_zero", 1, 32'h00004020, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b000, 0, 32'h4020, 32'h0, 32'h0, 1, 0, 0, 5'd8));
      issue("addi_neg", 1, 32'h2029FFFF, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b000, 1, 32'hFFFFFFFF, 32'h100, 32'h0, 1, 0, 0, 5'd9));
      issue("ori_zext", 1, 32'h34CA8001, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b110, 1, 32'h00008001, 32'h3, 32'h0, 1, 0, 0, 5'd10));
      issue("sw", 1, 32'hAC260008, 0, 0, 0, 5'd0, 32'h0, sw_b);
      issue("stall_1_wb", 1, 32'h00A63820, 1, 0, 1, 5'd1, 32'h200, sw_b);
      issue("stall_2", 1, 32'h3022FFFF, 1, 0, 0, 5'd0, 32'h0, sw_b);
      issue("flush_over_stall", 1, 32'h00A63820, 1, 1, 0, 5'd0, 32'h0, zero_b);
      issue("illegal_op", 1, 32'hFC000000, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 1, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0));
      issue("illegal_funct", 1, 32'h00000022, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 1, 3'b000, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0));
      issue("ori_after_stall_wb", 1, 32'h342B0000, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b110, 1, 32'h0, 32'h200, 32'h0, 1, 0, 0, 5'd11));
      issue("flush_only", 1, 32'h2029FFFF, 0, 1, 0, 5'd0, 32'h0, zero_b);
      issue("validd_low", 0, 32'h2029FFFF, 0, 0, 0, 5'd0, 32'h0, zero_b);
      issue("addi_pre_reset", 1, 32'h2029FFFF, 0, 0, 0, 5'd0, 32'h0,
            mk(1, 0, 3'b000, 1, 32'hFFFFFFFF, 32'h200, 32'h0, 1, 0, 0, 5'd9));
      idle();

      // asynchronous reset in the middle of the low clock phase
      #1 rst_n = 1'b0;
      #1 compare("reset_async", zero_b);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 1; k < 32; k += 2) begin
         logic [4:0]  rs;
         logic [4:0]  rt;
         logic [31:0] ins;
         rs  = k[4:0];
         rt  = rs + 5'd1;
         ins = {6'd0, rs, rt, 5'd1, 5'd0, 6'h20};
         issue($sformatf("rf_cleared_r%0d", k), 1, ins, 0, 0, 0, 5'd0, 32'h0,
               mk(1, 0, 3'b000, 0, 32'h0820, 32'h0, 32'h0, 1, 0, 0, 5'd1));
      end
      idle();

      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
